// File: rtl/cic_pkg.sv
// rtl/cic_pkg.sv - shared CIC types and ratio helpers
package cic_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } cic_state_t;

  function automatic int rate_width(input int r_max);
    return $clog2(r_max + 1);
  endfunction

  // A ratio of 0 is meaningless, so it decimates by 1.
  function automatic int clamp_ratio(input int rate, input int r_max);
    if (rate == 0)
      return 1;
    if (rate > r_max)
      return r_max;
    return rate;
  endfunction

endpackage

// File: rtl/cic_decim_phase_ctr.sv
// rtl/cic_decim_phase_ctr.sv - decimation phase counter with latched ratio
import cic_pkg::*;

module cic_decim_phase_ctr #(
  parameter int R_MAX = 8,
  parameter int RW    = rate_width(R_MAX)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_clr,
  input  logic          i_valid,
  input  logic          i_idle,
  input  logic [RW-1:0] i_rate,
  output logic          o_term
);

  logic [RW-1:0] r_cnt;
  logic [RW-1:0] r_rate_q;
  logic [RW-1:0] w_eff;
  logic          w_term;

  assign w_eff = RW'(clamp_ratio(int'(i_rate), R_MAX));

  // When no window is open the fresh ratio decides; otherwise the latched one.
  assign w_term = i_idle ? (w_eff == RW'(1)) : (r_cnt == r_rate_q - RW'(1));
  assign o_term = w_term;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt    <= '0;
      r_rate_q <= RW'(1);
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_valid) begin
      if (i_idle)
        r_rate_q <= w_eff;
      r_cnt <= w_term ? '0 : r_cnt + RW'(1);
    end
  end

endmodule

// File: rtl/cic_decimator.sv
// rtl/cic_decimator.sv - CIC rate-change stage; CIC_DECIM_OVF_EN enables overflow tracking
import cic_pkg::*;

module cic_decimator #(
  parameter int WIDTH = 8,
  parameter int R_MAX = 8
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [WIDTH-1:0]             a,
  input  logic                         a_valid,
  input  logic                         ovf_in,
  input  logic [rate_width(R_MAX)-1:0] rate,
  input  logic                         clr,
  output logic [WIDTH-1:0]             y,
  output logic                         y_valid,
  output logic                         overflow
);

  localparam int RW = rate_width(R_MAX);

  cic_state_t       r_state;
  logic [WIDTH-1:0] r_y;
  logic             r_y_valid;
  logic             w_term;

  cic_decim_phase_ctr #(
    .R_MAX (R_MAX),
    .RW    (RW)
  ) u_phase_ctr (
    .clk     (clk),
    .rstn    (rstn),
    .i_clr   (clr),
    .i_valid (a_valid),
    .i_idle  (r_state == ST_IDLE),
    .i_rate  (rate),
    .o_term  (w_term)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_y       <= '0;
      r_y_valid <= 1'b0;
    end else begin
      r_y_valid <= 1'b0;
      if (clr) begin
        r_state <= ST_IDLE;
      end else if (a_valid) begin
        if (w_term) begin
          r_y       <= a;
          r_y_valid <= 1'b1;
          r_state   <= ST_IDLE;
        end else begin
          r_state <= ST_ACC;
        end
      end
    end
  end

  assign y       = r_y;
  assign y_valid = r_y_valid;

`ifdef CIC_DECIM_OVF_EN
  logic r_acc;
  logic r_overflow;

  // The emitting sample's own flag is folded in before the window closes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_acc      <= 1'b0;
      r_overflow <= 1'b0;
    end else if (clr) begin
      r_acc <= 1'b0;
    end else if (a_valid) begin
      if (w_term) begin
        r_overflow <= r_acc | ovf_in;
        r_acc      <= 1'b0;
      end else begin
        r_acc <= r_acc | ovf_in;
      end
    end
  end

  assign overflow = r_overflow;
`else
  logic w_unused_ovf;
  assign w_unused_ovf = ovf_in;
  assign overflow     = 1'b0;
`endif

endmodule

// File: tb/tb_cic_decimator.sv
// tb/tb_cic_decimator.sv - directed self-checking bench for cic_decimator
module tb_cic_decimator;

  localparam int WIDTH = 8;
  localparam int R_MAX = 8;
  localparam int RW    = $clog2(R_MAX + 1);
`ifdef CIC_DECIM_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic             a_valid = 1'b0;
  logic             ovf_in = 1'b0;
  logic [RW-1:0]    rate = '0;
  logic             clr = 1'b0;
  logic [WIDTH-1:0] y;
  logic             y_valid;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  cic_decimator #(
    .WIDTH (WIDTH),
    .R_MAX (R_MAX)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .a        (a),
    .a_valid  (a_valid),
    .ovf_in   (ovf_in),
    .rate     (rate),
    .clr      (clr),
    .y        (y),
    .y_valid  (y_valid),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] av, input logic v, input logic ov, input logic c,
                       input logic exp_v, input logic [7:0] exp_y, input logic exp_o,
                       input string tag);
    a       = av;
    a_valid = v;
    ovf_in  = ov;
    clr     = c;
    @(posedge clk);
    #1;
    check({tag, ".y_valid"}, 32'(y_valid), 32'(exp_v));
    check({tag, ".y"}, 32'(y), 32'(exp_y));
    check({tag, ".overflow"}, 32'(overflow), 32'(exp_o));
  endtask

  initial begin
    logic [7:0] ey;
    logic       ev;
    logic       eo;
    ey = 8'd0;

    rstn = 1'b0;
    drive(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, "reset");
    rstn = 1'b1;

    rate = RW'(4);
    for (int i = 0; i < 12; i++) begin
      ev = (i % 4 == 3);
      if (ev) ey = 8'(i);
      drive(8'(i), 1'b1, 1'b0, 1'b0, ev, ey, 1'b0, "r4");
    end
    drive(8'd99, 1'b0, 1'b0, 1'b0, 1'b0, ey, 1'b0, "hold");

    rate = RW'(0);
    for (int i = 5; i < 8; i++)
      drive(8'(i), 1'b1, 1'b0, 1'b0, 1'b1, 8'(i), 1'b0, "r0");
    ey = 8'd7;

    rate = RW'(12);
    for (int i = 0; i < 16; i++) begin
      ev = (i % 8 == 7);
      if (ev) ey = 8'(20 + i);
      drive(8'(20 + i), 1'b1, 1'b0, 1'b0, ev, ey, 1'b0, "r12");
    end

    rate = RW'(3);
    drive(8'd10, 1'b1, 1'b0, 1'b0, 1'b0, ey, 1'b0, "gap0");
    drive(8'd0,  1'b0, 1'b0, 1'b0, 1'b0, ey, 1'b0, "gap1");
    drive(8'd20, 1'b1, 1'b0, 1'b0, 1'b0, ey, 1'b0, "gap2");
    drive(8'd0,  1'b0, 1'b0, 1'b0, 1'b0, ey, 1'b0, "gap3");
    drive(8'd30, 1'b1, 1'b0, 1'b0, 1'b1, 8'd30, 1'b0, "gap4");
    ey = 8'd30;

    rate = RW'(4);
    for (int i = 0; i < 8; i++) begin
      ev = (i == 3) || (i == 7);
      if (ev) ey = 8'(40 + i);
      eo = (i >= 3 && i < 7) ? OVF_ON : 1'b0;
      drive(8'(40 + i), 1'b1, (i == 1), 1'b0, ev, ey, eo, "ovf");
    end

    rate = RW'(4);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) rate = RW'(2);
      ev = (i == 3) || (i == 5) || (i == 7);
      if (ev) ey = 8'(50 + i);
      drive(8'(50 + i), 1'b1, 1'b0, 1'b0, ev, ey, 1'b0, "rchg");
    end

    rate = RW'(4);
    drive(8'd60, 1'b1, 1'b0, 1'b0, 1'b0, ey, 1'b0, "pre_rst0");
    drive(8'd61, 1'b1, 1'b0, 1'b0, 1'b0, ey, 1'b0, "pre_rst1");
    rstn = 1'b0;
    ey   = 8'd0;
    drive(8'd62, 1'b0, 1'b0, 1'b0, 1'b0, ey, 1'b0, "in_rst");
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ev = (i == 3);
      if (ev) ey = 8'(70 + i);
      drive(8'(70 + i), 1'b1, 1'b0, 1'b0, ev, ey, 1'b0, "post_rst");
    end

    drive(8'd80, 1'b1, 1'b0, 1'b0, 1'b0, ey, 1'b0, "pre_clr0");
    drive(8'd81, 1'b1, 1'b1, 1'b0, 1'b0, ey, 1'b0, "pre_clr1");
    drive(8'd82, 1'b1, 1'b0, 1'b1, 1'b0, ey, 1'b0, "clr");
    for (int i = 0; i < 4; i++) begin
      ev = (i == 3);
      if (ev) ey = 8'(90 + i);
      drive(8'(90 + i), 1'b1, 1'b0, 1'b0, ev, ey, 1'b0, "post_clr");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
